// File: rtl/uart_rx_framer.sv
// 8-bit UART receiver: 2-flop synchronizer, mid-bit sampling, framing checks.
// Optional even parity bit is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_framer #(
  parameter logic [15:0] CLKS_PER_BIT = 16'd5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Frame_Err,
  output logic       o_Parity_Err,
  output logic       o_Busy
);

  localparam logic [15:0] HALF_M1 = (CLKS_PER_BIT >> 1) - 16'd1;
  localparam logic [15:0] FULL_M1 = CLKS_PER_BIT - 16'd1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic        rx_m, rx_s;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  bit_idx, bit_idx_nxt;
  logic [7:0]  shift;
  logic        shift_en;
  logic        tick;
  logic        dv_nxt, ferr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_Rx_Serial;
      rx_s <= rx_m;
    end
  end

  // START waits half a bit to land mid-start-bit; every later sample is one bit apart.
  always_comb begin
    if (state == START) tick = (cnt == HALF_M1);
    else                tick = (cnt == FULL_M1);
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic par_cap;
  logic par_bad;
  logic perr_nxt;

  assign par_bad = (^shift) != par_bit;
`endif

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 16'd1;
    bit_idx_nxt = bit_idx;
    shift_en    = 1'b0;
    dv_nxt      = 1'b0;
    ferr_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_cap     = 1'b0;
    perr_nxt    = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_nxt     = 16'd0;
        bit_idx_nxt = 3'd0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (tick) begin
          cnt_nxt   = 16'd0;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_nxt     = 16'd0;
          shift_en    = 1'b1;
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          cnt_nxt   = 16'd0;
          par_cap   = 1'b1;
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          cnt_nxt = 16'd0;
          if (!rx_s) begin
            ferr_nxt  = 1'b1;
            state_nxt = WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad) begin
            perr_nxt  = 1'b1;
            state_nxt = IDLE;
`endif
          end else begin
            dv_nxt    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_nxt = 16'd0;
        if (rx_s) state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = 16'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 16'd0;
      bit_idx     <= 3'd0;
      o_Rx_DV     <= 1'b0;
      o_Rx_Byte   <= 8'h00;
      o_Frame_Err <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      bit_idx     <= bit_idx_nxt;
      o_Rx_DV     <= dv_nxt;
      o_Frame_Err <= ferr_nxt;
      if (dv_nxt) o_Rx_Byte <= shift;
    end
  end

  // Datapath shift register; its content is only published through o_Rx_Byte.
  always_ff @(posedge clk) begin
    if (shift_en) shift <= {rx_s, shift[7:1]};
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (par_cap) par_bit <= rx_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_Parity_Err <= 1'b0;
    else        o_Parity_Err <= perr_nxt;
  end
`else
  assign o_Parity_Err = 1'b0;
`endif

  assign o_Busy = (state != IDLE);

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16'd5, giving clock cycles per UART bit (legal range 4..65535).
REQ-002 The block SHALL have port clk, input, 1, system clock (50 MHz nominal).
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port i_Rx_Serial, input, 1, asynchronous serial line (idle high).
REQ-005 The block SHALL have port o_Rx_DV, output, 1, one-cycle pulse marking a good received byte.
REQ-006 The block SHALL have port o_Rx_Byte, output, 8, last good received byte.
REQ-007 The block SHALL have port o_Frame_Err, output, 1, one-cycle pulse when the stop bit is sampled low.
REQ-008 The block SHALL have port o_Parity_Err, output, 1, one-cycle pulse on parity mismatch (tied 0 without the parity feature).
REQ-009 The block SHALL have port o_Busy, output, 1, high whenever the state is not IDLE.

Function
REQ-010 The block SHALL pass i_Rx_Serial through a 2-flop synchronizer; "rx_s" denotes the second flop, and all decisions SHALL use rx_s only.
REQ-011 The block SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE, with a 16-bit bit-time counter and a 3-bit bit index.
REQ-012 IDLE -> START SHALL occur in the cycle rx_s is first seen low (t0), with the counter cleared.
REQ-013 START SHALL sample rx_s at t0 + CLKS_PER_BIT/2 (floor): low -> DATA; high -> glitch, back to IDLE, no output pulse.
REQ-014 DATA SHALL sample 8 bits LSB-first; bit i is sampled at t0 + CLKS_PER_BIT/2 + (i+1)*CLKS_PER_BIT.
REQ-015 After bit 7, the next state SHALL be PARITY when the feature is enabled, otherwise STOP; each is sampled one CLKS_PER_BIT after the previous sample.
REQ-016 At the STOP sample, if rx_s=1 and there is no parity error, o_Rx_DV SHALL pulse and o_Rx_Byte SHALL update in the following cycle, and the next state SHALL be IDLE.
REQ-017 At the STOP sample, if rx_s=0, o_Frame_Err SHALL pulse in the following cycle, there SHALL be no o_Rx_DV pulse, o_Rx_Byte SHALL remain unchanged, and the next state SHALL be WAIT_IDLE.
REQ-018 WAIT_IDLE SHALL remain until rx_s=1, then go to IDLE, so a held-low line (break) yields exactly one o_Frame_Err.
REQ-019 o_Rx_Byte SHALL change only together with o_Rx_DV and otherwise hold its value.
REQ-020 o_Rx_DV, o_Frame_Err and o_Parity_Err SHALL each be high for exactly one cycle per event and SHALL be mutually exclusive.
REQ-021 A falling edge seen in the cycle IDLE is re-entered from STOP SHALL start a new frame, so back-to-back frames with a one-bit stop SHALL be received without loss.

Reset
REQ-022 rst_n low SHALL immediately (asynchronously) set: state IDLE, synchronizer flops 1, counter 0, bit index 0, o_Rx_DV 0, o_Rx_Byte 8'h00, o_Frame_Err 0, o_Parity_Err 0, o_Busy 0.
REQ-023 Reset asserted mid-frame SHALL discard the partial byte without producing any pulse; after release, the block SHALL wait for a fresh falling edge.

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined: PARITY state compiled in, even parity expected; on mismatch at the STOP sample, o_Parity_Err SHALL pulse instead of o_Rx_DV, o_Rx_Byte SHALL be unchanged, and the next state SHALL be IDLE (or WAIT_IDLE if the stop bit is also low, in which case o_Frame_Err takes priority).
REQ-025 Macro UART_RX_PARITY_EN undefined: no PARITY state, o_Parity_Err constant 0, frame is 10 bits.

Verification (CLKS_PER_BIT=5, t0 = cycle rx_s first low)
REQ-026 Frame 0xA5, no parity -> o_Rx_DV pulse at t0+48, o_Rx_Byte=8'hA5, no error pulses.
REQ-027 Frames 0x12 then 0x34 back-to-back, one stop bit each -> two o_Rx_DV pulses, 10 bit-times apart, bytes 8'h12 then 8'h34.
REQ-028 i_Rx_Serial low for 2 cycles then high -> o_Busy returns 0 by t0+3, no output pulses.
REQ-029 Frame 0x3C with stop bit 0, then line held low for 20 bit-times -> single o_Frame_Err pulse at t0+48, o_Rx_Byte unchanged, next valid frame 0x5A received after the line returns high.
REQ-030 rst_n pulsed low during DATA bit 3 -> all outputs 0 immediately, no pulses, subsequent frame 0x5A gives o_Rx_Byte=8'h5A.
REQ-031 With UART_RX_PARITY_EN: 0x03 with parity bit 0 -> o_Rx_DV at t0+53; 0x03 with parity bit 1 -> o_Parity_Err at t0+53, no o_Rx_DV.
